// File: rtl/dmem_responder_pkg.sv
// dmem_responder_pkg: shared state type and defaults for the data-memory responder
package dmem_responder_pkg;
    typedef enum logic [1:0] {IDLE, WAIT, RESP} dmem_state_e;
    localparam logic [31:0] DMEM_BASE_DEFAULT = 32'h0001_0000;
    localparam int DMEM_MAX_WAIT = 15;
endpackage

// File: rtl/dmem_ram.sv
// dmem_ram: single-port word RAM with byte-enable write and a clearable registered read port
module dmem_ram #(
    parameter int    DEPTH     = 4096,
    parameter string INIT_FILE = "",
    localparam int   AW        = $clog2(DEPTH)
) (
    input  logic          i_clk,
    input  logic          i_clr,
    input  logic          i_re,
    input  logic [3:0]    i_we,
    input  logic [AW-1:0] i_addr,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [DEPTH];
    logic [31:0] r_q;
    always_ff @(posedge i_clk) begin
        for (int k = 0; k < 4; k++)
            if (i_we[k]) r_mem[i_addr][8*k +: 8] <= i_wdata[8*k +: 8];
    end
    always_ff @(posedge i_clk) r_q <= i_clr ? '0 : i_re ? r_mem[i_addr] : r_q;
    assign o_rdata = r_q;
endmodule

// File: rtl/dmem_responder.sv
// dmem_responder: wait-stated word RAM responder for the core load/store bus
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] BASE_ADDR   = DMEM_BASE_DEFAULT,
    parameter int          WAIT_CYCLES = 1,
    parameter string       INIT_FILE   = ""
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        mem_valid_i,
    input  logic        mem_write_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic [3:0]  mem_wstrb_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ready_o,
    output logic        mem_err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WAIT_LD = 4'(WAIT_CYCLES > DMEM_MAX_WAIT ? DMEM_MAX_WAIT : WAIT_CYCLES);
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);
    dmem_state_e r_state;
    logic [3:0]  r_cnt;
    logic        r_write;
    logic        r_ready;
    logic        r_err;
    logic [31:0] r_addr;
    logic [31:0] r_wdata;
    logic [3:0]  r_wstrb;
    logic [31:0] w_addr;
    logic [31:0] w_off;
    logic        w_write;
    logic        w_in_range;
    logic        w_go_resp;
    logic        w_commit;
    logic        w_unused;
    // In IDLE the RAM sees the live request so a zero-wait read is ready in RESP
    always_comb begin
        w_addr = r_state == IDLE ? mem_addr_i : r_addr;
        w_write = r_state == IDLE ? mem_write_i : r_write;
        w_off = w_addr - BASE_ADDR;
        w_in_range = w_addr >= BASE_ADDR && {1'b0, w_addr} < LIMIT;
        w_go_resp = mem_valid_i && (r_state == IDLE ? WAIT_LD == 4'd0 : r_state == WAIT && r_cnt == 4'd1);
        w_commit = rst_n_i && r_state == RESP && r_write && w_in_range;
    end
    assign w_unused = ^{w_off[31:AW+2], w_off[1:0]};
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            r_state <= IDLE;
            r_cnt <= '0;
            r_ready <= 1'b0;
            r_err <= 1'b0;
        end else begin
            r_ready <= w_go_resp;
            r_err <= w_go_resp && !w_in_range;
            case (r_state)
                IDLE: if (mem_valid_i) begin
                    r_addr <= mem_addr_i;
                    r_write <= mem_write_i;
                    r_wdata <= mem_wdata_i;
                    r_wstrb <= mem_wstrb_i;
                    r_cnt <= WAIT_LD;
                    r_state <= WAIT_LD == 4'd0 ? RESP : WAIT;
                end
                WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                    r_state <= !mem_valid_i ? IDLE : r_cnt == 4'd1 ? RESP : WAIT;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
    assign mem_ready_o = r_ready;
    assign mem_err_o = r_err;
    dmem_ram #(.DEPTH(DEPTH_WORDS), .INIT_FILE(INIT_FILE)) u_ram (
        .i_clk  (clk_i),
        .i_clr  (!rst_n_i || (w_go_resp && !w_in_range)),
        .i_re   (w_go_resp && !w_write && w_in_range),
        .i_we   ({4{w_commit}} & r_wstrb),
        .i_addr (w_off[AW+1:2]),
        .i_wdata(r_wdata),
        .o_rdata(mem_rdata_o)
    );
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed and random checks of three responders (wait 1, 0, 3) against a word-map model
module tb_dmem_responder;
    localparam logic [31:0] BASE = 32'h0001_0000;
    localparam int DEPTH = 4096;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic        rst_n [3];
    logic        valid [3];
    logic        write [3];
    logic [31:0] addr  [3];
    logic [31:0] wdata [3];
    logic [3:0]  wstrb [3];
    logic [31:0] rdata [3];
    logic        ready [3];
    logic        err   [3];
    int wcs [3] = '{1, 0, 3};
    logic [31:0] model [int];
    logic [31:0] exp_rd [3];
    int n_checks = 0;
    int n_errors = 0;
    dmem_responder #(.WAIT_CYCLES(1)) u_w1 (
        .clk_i(clk), .rst_n_i(rst_n[0]), .mem_valid_i(valid[0]), .mem_write_i(write[0]),
        .mem_addr_i(addr[0]), .mem_wdata_i(wdata[0]), .mem_wstrb_i(wstrb[0]),
        .mem_rdata_o(rdata[0]), .mem_ready_o(ready[0]), .mem_err_o(err[0]));
    dmem_responder #(.WAIT_CYCLES(0)) u_w0 (
        .clk_i(clk), .rst_n_i(rst_n[1]), .mem_valid_i(valid[1]), .mem_write_i(write[1]),
        .mem_addr_i(addr[1]), .mem_wdata_i(wdata[1]), .mem_wstrb_i(wstrb[1]),
        .mem_rdata_o(rdata[1]), .mem_ready_o(ready[1]), .mem_err_o(err[1]));
    dmem_responder #(.WAIT_CYCLES(3)) u_w3 (
        .clk_i(clk), .rst_n_i(rst_n[2]), .mem_valid_i(valid[2]), .mem_write_i(write[2]),
        .mem_addr_i(addr[2]), .mem_wdata_i(wdata[2]), .mem_wstrb_i(wstrb[2]),
        .mem_rdata_o(rdata[2]), .mem_ready_o(ready[2]), .mem_err_o(err[2]));
    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask
    function automatic bit in_range(input logic [31:0] a);
        return 64'(a) >= 64'(BASE) && 64'(a) < 64'(BASE) + 64'(4 * DEPTH);
    endfunction
    function automatic int key_of(input int i, input logic [31:0] a);
        return i * DEPTH + int'((a - BASE) >> 2);
    endfunction
    // Called one step after a rising edge with the responder idle
    task automatic txn(input int i, input bit wr, input logic [31:0] a, input logic [31:0] d,
                       input logic [3:0] s, input string tag);
        int n = 0;
        bit ok = in_range(a);
        int key = key_of(i, a);
        valid[i] = 1'b1;
        write[i] = wr;
        addr[i] = a;
        wdata[i] = d;
        wstrb[i] = s;
        do begin
            @(posedge clk);
            #1;
            n++;
        end while (!ready[i] && n < 40);
        valid[i] = 1'b0;
        check({tag, ".lat"}, 32'(n), 32'(wcs[i] + 1));
        check({tag, ".err"}, 32'(err[i]), 32'(!ok));
        if (wr && ok)
            for (int k = 0; k < 4; k++)
                if (s[k]) model[key][8*k +: 8] = d[8*k +: 8];
        if (!ok) exp_rd[i] = '0;
        else if (!wr) exp_rd[i] = model[key];
        check({tag, ".rdata"}, rdata[i], exp_rd[i]);
        @(posedge clk);
        #1;
        check({tag, ".pulse"}, 32'(ready[i]), 32'd0);
    endtask
    task automatic init_window(input int i);
        for (int w = 0; w < 8; w++) txn(i, 1'b1, BASE + 32'(4 * w), $urandom, 4'hf, "init");
        txn(i, 1'b1, BASE + 32'(4 * (DEPTH - 1)), $urandom, 4'hf, "init");
    endtask
    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end
    initial begin
        bit seen;
        int n;
        for (int i = 0; i < 3; i++) begin
            rst_n[i] = 1'b0;
            valid[i] = 1'b0;
            write[i] = 1'b0;
            addr[i] = '0;
            wdata[i] = '0;
            wstrb[i] = '0;
            exp_rd[i] = '0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int i = 0; i < 3; i++) begin
            check("reset.rdata", rdata[i], 32'd0);
            check("reset.ready", 32'(ready[i]), 32'd0);
            check("reset.err", 32'(err[i]), 32'd0);
            rst_n[i] = 1'b1;
        end
        @(posedge clk);
        #1;
        txn(0, 1'b1, 32'h0001_0010, 32'hDEAD_BEEF, 4'hf, "w1.store");
        txn(0, 1'b0, 32'h0001_0010, 32'h0, 4'h0, "w1.load");
        check("w1.deadbeef", rdata[0], 32'hDEAD_BEEF);
        txn(0, 1'b1, 32'h0001_0020, 32'h1122_3344, 4'hf, "w1.fill");
        txn(0, 1'b1, 32'h0001_0020, 32'h0000_AA00, 4'b0010, "w1.byte");
        txn(0, 1'b1, 32'h0001_0020, 32'hFFFF_FFFF, 4'b0000, "w1.nostrb");
        txn(0, 1'b0, 32'h0001_0022, 32'h0, 4'h0, "w1.byteread");
        check("w1.byteval", rdata[0], 32'h1122_AA44);
        txn(0, 1'b1, BASE, 32'h0BAD_F00D, 4'hf, "w1.word0");
        txn(0, 1'b0, 32'h0000_FFFC, 32'h0, 4'h0, "w1.below");
        txn(0, 1'b1, BASE + 32'(4 * DEPTH), 32'h5555_5555, 4'hf, "w1.above");
        txn(0, 1'b0, BASE, 32'h0, 4'h0, "w1.alias");
        check("w1.word0val", rdata[0], 32'h0BAD_F00D);
        init_window(1);
        init_window(2);
        valid[1] = 1'b1;
        write[1] = 1'b0;
        addr[1] = BASE + 32'd8;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ready[1] && n < 40);
        check("b2b.first", 32'(n), 32'd1);
        check("b2b.rd1", rdata[1], model[key_of(1, BASE + 32'd8)]);
        addr[1] = BASE + 32'd12;
        n = 0;
        do begin @(posedge clk); #1; n++; end while (!ready[1] && n < 40);
        check("b2b.gap", 32'(n), 32'd2);
        check("b2b.rd2", rdata[1], model[key_of(1, BASE + 32'd12)]);
        exp_rd[1] = rdata[1];
        valid[1] = 1'b0;
        @(posedge clk);
        #1;
        valid[2] = 1'b1;
        write[2] = 1'b1;
        addr[2] = BASE + 32'd16;
        wdata[2] = 32'hCAFE_F00D;
        wstrb[2] = 4'hf;
        repeat (2) begin @(posedge clk); #1; end
        valid[2] = 1'b0;
        seen = 1'b0;
        repeat (6) begin @(posedge clk); #1; seen |= ready[2]; end
        check("abort.ready", 32'(seen), 32'd0);
        txn(2, 1'b0, BASE + 32'd16, 32'h0, 4'h0, "abort.readback");
        valid[2] = 1'b1;
        write[2] = 1'b1;
        addr[2] = BASE + 32'd20;
        wdata[2] = 32'h1234_5678;
        wstrb[2] = 4'hf;
        @(posedge clk);
        #1;
        rst_n[2] = 1'b0;
        valid[2] = 1'b0;
        @(posedge clk);
        #1;
        rst_n[2] = 1'b1;
        exp_rd[2] = '0;
        check("rst.rdata", rdata[2], 32'd0);
        check("rst.err", 32'(err[2]), 32'd0);
        seen = ready[2];
        repeat (6) begin @(posedge clk); #1; seen |= ready[2]; end
        check("rst.ready", 32'(seen), 32'd0);
        txn(2, 1'b0, BASE + 32'd20, 32'h0, 4'h0, "rst.readback");
        for (int i = 0; i < 3; i++) begin
            for (int t = 0; t < 40; t++) begin
                int r = $urandom_range(0, 11);
                logic [31:0] a = r < 8 ? BASE + 32'(4 * r) : r == 8 ? BASE + 32'(4 * (DEPTH - 1)) :
                                 r == 9 ? BASE - 32'd4 : r == 10 ? BASE + 32'(4 * DEPTH) : 32'hFFFF_FFF0;
                a[1:0] = 2'($urandom_range(0, 3));
                txn(i, 1'($urandom_range(0, 1)), a, $urandom, 4'($urandom_range(0, 15)), "rand");
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
